ahb_master_path: RTL and testbench
==================================

# ahb_master_path

Initiator-side data path for the single-slave bus. It accepts one transfer request at a time from local logic (read or write, 16-bit address, 32-bit data) and drives the bus: `HADDR1`, `HWDATA1`, `hsel_1`, the slave capture strobes `sa1`/`sw1`, and `hwrite_1`. It then waits for the slave's `sl_rdy_1`/`slrsp_1` handshake and returns completion, error and read data to the requester. It sits between the system's request logic and `slave_data_path`, driving the inputs that block latches.

## Interface
- `ADDR_W`, 16, bus address width.
- `DATA_W`, 32, bus data width.
- `TIMEOUT`, 15, maximum DATA-phase wait cycles without `sl_rdy_1` before the transfer is aborted; legal range ≥1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: transfer request; sampled only in IDLE.
- `wr` in 1: 1 = write, 0 = read; captured with `req`.
- `addr` in ADDR_W: transfer address; captured with `req`.
- `wdata` in DATA_W: write data; captured with `req`.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse on OKAY completion.
- `err` out 1: one-cycle pulse on slave ERROR response or timeout.
- `rdata` out DATA_W: read data; updated only on an OKAY read.
- `HADDR1` out ADDR_W: bus address.
- `HWDATA1` out DATA_W: bus write data.
- `hsel_1` out 1: slave select.
- `hwrite_1` out 1: transfer direction.
- `sa1` out 1: address-capture strobe to the slave.
- `sw1` out 1: write-data-capture strobe to the slave.
- `sl_rdy_1` in 1: slave ready; meaningful only in DATA.
- `slrsp_1` in 1: slave response, qualified by `sl_rdy_1`; 0 = OKAY, 1 = ERROR.
- `hrdata_1` in DATA_W: slave read data, qualified by `sl_rdy_1`.

## Operation
- FSM states: IDLE, ADDR, DATA. All outputs are registered.
- **IDLE**
  - `busy`=0, `hsel_1`=0, `sa1`=0, `sw1`=0.
  - On `req`=1: capture `wr`, `addr` and `wdata`; go to ADDR.
- **ADDR** (exactly 1 cycle)
  - `hsel_1`=1, `sa1`=1, `HADDR1`=captured address, `hwrite_1`=captured `wr`.
  - `sl_rdy_1` is ignored.
  - Go to DATA.
- **DATA**
  - `hsel_1`=1 and `sa1`=0.
  - `HWDATA1`=captured data from DATA entry; stable until the next transfer.
  - `sw1`=1 for the first DATA cycle of a write only; 0 for reads.
  - The wait counter clears on DATA entry and increments on each DATA cycle with `sl_rdy_1`=0.
- **DATA exit**, when `sl_rdy_1`=1 is sampled in DATA:
  - `slrsp_1`=0: `done` pulses. On a read, `rdata`←`hrdata_1`.
  - `slrsp_1`=1: `err` pulses and `rdata` is unchanged.
  - Either way, go to IDLE.
- **Timeout:** when the counter reaches TIMEOUT with `sl_rdy_1`=0, `err` pulses and the FSM goes to IDLE.
- **Priority:** if `sl_rdy_1`=1 on the same cycle the counter would hit TIMEOUT, the slave response wins.
- **Hold values:** `HADDR1`, `HWDATA1` and `hwrite_1` keep their last values in IDLE (no return-to-zero).
- **Back-to-back:** `req` while `busy`=1 is ignored; it is not queued. `req` sampled in the cycle `done`/`err` is high is accepted, since the FSM is already in IDLE.
- **Counter width:** clog2(TIMEOUT+1); it never wraps.

## Timing
- **Reset:** `rst`=0 immediately forces IDLE and sets every output to 0: `busy`, `done`, `err`, `rdata`, `HADDR1`, `HWDATA1`, `hsel_1`, `hwrite_1`, `sa1`, `sw1`, plus the counter.
  - A reset mid-transfer produces no `done`/`err`.
  - The first `req` is sampled on the first rising edge after `rst` goes high.
- **Sequence** (edge E0 = `req` sampled):
  - ADDR is visible in the cycle after E0.
  - DATA from E1 onward.
  - Ready sampled at edge Ek → `done`/`err`/`rdata` visible from Ek, for one cycle.
- **Minimum latency:** `req` to `done` = 3 edges (zero-wait slave).
- **Throughput:** with a zero-wait slave, one transfer per 3 cycles.
- **Timeout:** `err` appears TIMEOUT+1 edges after DATA entry.

## Test plan
- **Zero-wait write:** reset; `req`, `wr`=1, `addr`=16'h00A4, `wdata`=32'hDEADBEEF; slave holds `sl_rdy_1`=1, `slrsp_1`=0 → `sa1`+`hsel_1` with `HADDR1`=00A4 for 1 cycle, then `sw1`=1 with `HWDATA1`=DEADBEEF; `done` pulses on edge 3; `err`=0.
- **Read with 4 wait states:** `addr`=16'h0010, `wr`=0; `sl_rdy_1` rises on the 5th DATA cycle with `hrdata_1`=32'h12345678 → `sw1` never asserts; `busy`=1 throughout; `rdata`=12345678 with a single `done` pulse.
- **Error response:** write; `sl_rdy_1`=1 with `slrsp_1`=1 → `err` pulses for 1 cycle, `done`=0, `rdata` unchanged; then a new `req` in the `err` cycle is accepted.
- **Timeout:** TIMEOUT=15, `sl_rdy_1` held at 0 → `err` pulses 16 edges after DATA entry; FSM back in IDLE with `hsel_1`=0. A variant asserting `sl_rdy_1` exactly on the timeout cycle → `done`, not `err`.
- **Reset mid-transfer:** pull `rst` low during DATA → all outputs 0 immediately; no `done`/`err` after release; the next transfer completes normally.
- **Ignored request:** pulse `req` with `addr`=16'h0BAD while busy → the current transfer is unaffected; `HADDR1` never shows 0BAD.

Source files
------------

// File: rtl/ahb_master_path.sv
// Initiator-side bus data path: takes one local request at a time, runs the
// ADDR/DATA phases against a single slave and reports done/err/rdata.
module ahb_master_path #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] HADDR1,
  output logic [DATA_W-1:0] HWDATA1,
  output logic              hsel_1,
  output logic              hwrite_1,
  output logic              sa1,
  output logic              sw1,
  input  logic              sl_rdy_1,
  input  logic              slrsp_1,
  input  logic [DATA_W-1:0] hrdata_1
);

  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  state_t            r_state,  w_state;
  xfer_t             r_xfer,   w_xfer;
  logic [CW-1:0]     r_cnt,    w_cnt;
  logic              r_busy,   w_busy;
  logic              r_done,   w_done;
  logic              r_err,    w_err;
  logic [DATA_W-1:0] r_rdata,  w_rdata;
  logic [ADDR_W-1:0] r_haddr,  w_haddr;
  logic [DATA_W-1:0] r_hwdata, w_hwdata;
  logic              r_hsel,   w_hsel;
  logic              r_hwrite, w_hwrite;
  logic              r_sa,     w_sa;
  logic              r_sw,     w_sw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_xfer   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_haddr  <= '0;
      r_hwdata <= '0;
      r_hsel   <= 1'b0;
      r_hwrite <= 1'b0;
      r_sa     <= 1'b0;
      r_sw     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_xfer   <= w_xfer;
      r_cnt    <= w_cnt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_rdata  <= w_rdata;
      r_haddr  <= w_haddr;
      r_hwdata <= w_hwdata;
      r_hsel   <= w_hsel;
      r_hwrite <= w_hwrite;
      r_sa     <= w_sa;
      r_sw     <= w_sw;
    end
  end

  // Next-state logic computes the value each output takes after this edge,
  // so every bus/status output comes straight from a flop.
  always_comb begin
    w_state  = r_state;
    w_xfer   = r_xfer;
    w_cnt    = r_cnt;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_rdata  = r_rdata;
    w_haddr  = r_haddr;
    w_hwdata = r_hwdata;
    w_hsel   = 1'b0;
    w_hwrite = r_hwrite;
    w_sa     = 1'b0;
    w_sw     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state  = S_ADDR;
          w_xfer   = '{wr: wr, wdata: wdata};
          w_busy   = 1'b1;
          w_hsel   = 1'b1;
          w_sa     = 1'b1;
          w_haddr  = addr;
          w_hwrite = wr;
        end
      end
      S_ADDR: begin
        w_state  = S_DATA;
        w_cnt    = '0;
        w_busy   = 1'b1;
        w_hsel   = 1'b1;
        w_hwdata = r_xfer.wdata;
        w_sw     = r_xfer.wr;
      end
      S_DATA: begin
        // A ready slave beats the timeout on the same edge.
        if (sl_rdy_1) begin
          w_state = S_IDLE;
          if (!slrsp_1) begin
            w_done = 1'b1;
            if (!r_xfer.wr) w_rdata = hrdata_1;
          end else begin
            w_err = 1'b1;
          end
        end else if (r_cnt == TMO) begin
          w_state = S_IDLE;
          w_err   = 1'b1;
        end else begin
          w_cnt  = r_cnt + CW'(1);
          w_busy = 1'b1;
          w_hsel = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign HADDR1   = r_haddr;
  assign HWDATA1  = r_hwdata;
  assign hsel_1   = r_hsel;
  assign hwrite_1 = r_hwrite;
  assign sa1      = r_sa;
  assign sw1      = r_sw;

endmodule

// File: tb/tb_ahb_master_path.sv
// Scoreboard bench for ahb_master_path: driver pushes expected outcomes,
// a negedge monitor checks bus phases and completions against them.
module tb_ahb_master_path;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [15:0] HADDR1;
  logic [31:0] HWDATA1;
  logic        hsel_1, hwrite_1, sa1, sw1;
  logic        sl_rdy_1 = 1'b0, slrsp_1 = 1'b0;
  logic [31:0] hrdata_1 = '0;

  ahb_master_path #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .HADDR1(HADDR1), .HWDATA1(HWDATA1), .hsel_1(hsel_1), .hwrite_1(hwrite_1),
    .sa1(sa1), .sw1(sw1), .sl_rdy_1(sl_rdy_1), .slrsp_1(slrsp_1), .hrdata_1(hrdata_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    bit          is_err;
    logic [31:0] rdata;
    int          e0;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_rdata = '0;
  int          n_chk = 0, n_err = 0;
  bit          seen_sw = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_err"},   err,      0);
    chk({tag, "_rdata"}, rdata,    0);
    chk({tag, "_haddr"}, HADDR1,   0);
    chk({tag, "_hwdata"},HWDATA1,  0);
    chk({tag, "_hsel"},  hsel_1,   0);
    chk({tag, "_hwrite"},hwrite_1, 0);
    chk({tag, "_sa"},    sa1,      0);
    chk({tag, "_sw"},    sw1,      0);
  endtask

  // Monitor: everything sampled half a cycle after the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (sa1) begin
        if (q.size() == 0) chk("sa_unexpected", 1, 0);
        else begin
          chk("sa_cycle", cyc, q[0].e0);
          chk("sa_haddr", HADDR1, q[0].addr);
          chk("sa_hwrite", hwrite_1, q[0].wr);
          chk("sa_hsel", hsel_1, 1);
        end
        seen_sw = 0;
      end
      if (sw1) begin
        if (q.size() == 0) chk("sw_unexpected", 1, 0);
        else begin
          chk("sw_is_write", 1, q[0].wr);
          chk("sw_cycle", cyc, q[0].e0 + 1);
          chk("sw_hwdata", HWDATA1, q[0].wdata);
        end
        seen_sw = 1;
      end
      if (q.size() > 0 && cyc >= q[0].e0 && cyc < q[0].cyc) begin
        chk("busy_hold", busy, 1);
        chk("hsel_hold", hsel_1, 1);
        chk("haddr_hold", HADDR1, q[0].addr);
      end
      if (done || err) begin
        if (q.size() == 0) chk("resp_unexpected", {done, err}, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_kind", {done, err}, {~e.is_err, e.is_err});
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_rdata", rdata, e.rdata);
          chk("resp_idle", {busy, hsel_1}, 0);
          if (e.wr) chk("write_saw_sw", seen_sw, 1);
        end
      end
    end
  end

  // One transfer: slave answers after w wait cycles (w > TIMEOUT never answers).
  // junk drives spurious 16'h0BAD requests while busy; rst_at >= 0 resets mid-DATA.
  task automatic do_xfer(input bit w_wr, input logic [15:0] a, input logic [31:0] d,
                         input int w, input bit rsp, input logic [31:0] hr,
                         input bit junk, input int rst_at);
    exp_t e;
    int last;
    @(negedge clk);
    req = 1; wr = w_wr; addr = a; wdata = d;
    e.wr = w_wr; e.addr = a; e.wdata = d;
    e.is_err = (w > TIMEOUT) || rsp;
    e.rdata  = (!e.is_err && !w_wr) ? hr : m_rdata;
    m_rdata  = e.rdata;
    e.e0  = cyc + 1;
    e.cyc = e.e0 + ((w > TIMEOUT) ? TIMEOUT + 2 : w + 2);
    q.push_back(e);
    sl_rdy_1 = 1'($urandom); slrsp_1 = 1'($urandom); hrdata_1 = $urandom;
    @(posedge clk);
    @(negedge clk);
    req = junk; wr = 1'($urandom); wdata = $urandom;
    if (junk) addr = 16'h0BAD;
    sl_rdy_1 = 1'($urandom);
    @(posedge clk);
    last = (w > TIMEOUT) ? TIMEOUT : w;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        #2 rst = 0; req = 0; q.delete(); m_rdata = '0;
        #1 check_zero("midrst");
        @(negedge clk);
        rst = 1;
        return;
      end
      sl_rdy_1 = (k == w);
      slrsp_1  = (k == w) ? rsp : 1'($urandom);
      hrdata_1 = (k == w) ? hr : $urandom;
      req = junk & 1'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 0; sl_rdy_1 = 0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #3 check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1;
    do_xfer(1, 16'h00A4, 32'hDEADBEEF, 0, 0, 32'h0, 0, -1);
    idle(1);
    do_xfer(0, 16'h0010, 32'h0, 4, 0, 32'h12345678, 0, -1);
    idle(2);
    do_xfer(1, 16'h0020, 32'hCAFEF00D, 0, 1, 32'hFFFF0000, 0, -1);
    do_xfer(0, 16'h0030, 32'h0, 1, 0, 32'hA5A5A5A5, 0, -1);
    idle(1);
    do_xfer(0, 16'h0040, 32'h0, TIMEOUT + 1, 0, 32'h11111111, 0, -1);
    do_xfer(0, 16'h0050, 32'h0, TIMEOUT, 0, 32'h22222222, 0, -1);
    do_xfer(1, 16'h0060, 32'h33333333, 6, 0, 32'h0, 1, -1);
    idle(1);
    do_xfer(0, 16'h0070, 32'h0, 8, 0, 32'h44444444, 0, 2);
    do_xfer(0, 16'h0080, 32'h0, 2, 0, 32'h55555555, 0, -1);
    for (int i = 0; i < 40; i++) begin
      do_xfer(1'($urandom), 16'($urandom), $urandom, $urandom_range(0, TIMEOUT + 3),
              ($urandom % 4) == 0, $urandom, ($urandom % 3) == 0, -1);
      if ($urandom % 2) idle($urandom_range(0, 2));
    end
    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
